// File: rtl/rope_ctrl.sv
// Rope/hook controller: swings a pendulum rope, drops it on command, grabs a
// stone on contact and retracts it at a weight-dependent speed.
module rope_ctrl #(
    parameter int ORIGIN_X    = 160,
    parameter int ORIGIN_Y    = 45,
    parameter int FRAME_TICKS = 833334,
    parameter int DEG_MIN     = 15,
    parameter int DEG_MAX     = 165,
    parameter int DEG_START   = 90,
    parameter int LEN_MIN     = 10,
    parameter int LEN_MAX     = 200,
    parameter int FRAC        = 8,
    parameter int ROT_STEP    = 1,
    parameter int DOWN_STEP   = 768,
    parameter int UP_STEP     = 768
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic       hold,
    input  logic       go,
    input  logic       bomb,
    input  logic       hit,
    input  logic [3:0] hit_index,
    input  logic [2:0] hit_weight,
    input  logic [8:0] cos_mag,
    input  logic       cos_neg,
    input  logic [8:0] sin_mag,
    output logic [7:0] degree,
    output logic [9:0] rope_len,
    output logic [9:0] end_x,
    output logic [9:0] end_y,
    output logic [2:0] fsm_state,
    output logic       grabbed,
    output logic [3:0] grab_index,
    output logic       collect,
    output logic [3:0] collect_index,
    output logic       bomb_used
);

    localparam int LW  = FRAC + 10;
    localparam int LW1 = LW + 1;
    localparam int CW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_TICKS - 1);
    localparam logic [LW-1:0] LEN_LO    = LW'(LEN_MIN) << FRAC;
    localparam logic [LW-1:0] LEN_HI    = LW'(LEN_MAX) << FRAC;
    localparam logic [10:0]   LEN_MAX_W = 11'(LEN_MAX);
    localparam logic [9:0]    LEN_MIN_W = 10'(LEN_MIN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SWING   = 3'd1;
    localparam logic [2:0] S_DROP    = 3'd2;
    localparam logic [2:0] S_RETRACT = 3'd3;
    localparam logic [2:0] S_COLLECT = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_count;
    logic [7:0]    r_degree;
    logic          r_dir_up;
    logic [LW-1:0] r_length;
    logic          r_go_pending;
    logic          r_grabbed;
    logic [3:0]    r_grab_index;
    logic [2:0]    r_grab_weight;
    logic          r_collect;
    logic [3:0]    r_collect_index;
    logic          r_bomb_used;
    logic [9:0]    r_end_x;
    logic [9:0]    r_end_y;

    logic                w_tick;
    logic [9:0]          w_rope_len;
    logic signed [9:0]   w_deg_try;
    logic [LW:0]         w_len_add;
    logic [LW:0]         w_len_sub;
    logic [LW-1:0]       w_up_shift;
    logic [LW-1:0]       w_dec;
    logic                w_bomb_ok;
    logic                w_keep;
    logic [9:0]          w_dx;
    logic [9:0]          w_dy;

    assign w_tick     = (r_count == CNT_LAST) && !hold;
    assign w_rope_len = r_length[FRAC+9:FRAC];

    // Signed headroom so a step past either bound is visible before clamping.
    assign w_deg_try = r_dir_up ? $signed({2'b00, r_degree}) + $signed(10'(ROT_STEP))
                                : $signed({2'b00, r_degree}) - $signed(10'(ROT_STEP));

    assign w_len_add = {1'b0, r_length} + LW1'(DOWN_STEP);

    // A bomb in the same cycle as the retract step takes effect first.
    assign w_bomb_ok  = (r_state == S_RETRACT) && r_grabbed && bomb;
    assign w_keep     = r_grabbed && !bomb;
    assign w_up_shift = LW'(UP_STEP) >> r_grab_weight;
    assign w_dec      = w_keep ? ((w_up_shift == '0) ? LW'(1) : w_up_shift) : LW'(UP_STEP);
    assign w_len_sub  = {1'b0, r_length} - {1'b0, w_dec};

    assign w_dx = 10'((19'(w_rope_len) * 19'(cos_mag)) >> 8);
    assign w_dy = 10'((19'(w_rope_len) * 19'(sin_mag)) >> 8);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_count         <= '0;
            r_degree        <= 8'(DEG_START);
            r_dir_up        <= 1'b0;
            r_length        <= LEN_LO;
            r_go_pending    <= 1'b0;
            r_grabbed       <= 1'b0;
            r_grab_index    <= '0;
            r_grab_weight   <= '0;
            r_collect       <= 1'b0;
            r_collect_index <= '0;
            r_bomb_used     <= 1'b0;
        end else begin
            r_collect   <= 1'b0;
            r_bomb_used <= 1'b0;
            if (w_tick)
                r_count <= '0;
            else if (r_count != CNT_LAST)
                r_count <= r_count + CW'(1);

            if (!enable) begin
                r_state      <= S_IDLE;
                r_degree     <= 8'(DEG_START);
                r_dir_up     <= 1'b0;
                r_length     <= LEN_LO;
                r_go_pending <= 1'b0;
                r_grabbed    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_SWING;

                    S_SWING: begin
                        if (w_tick && r_go_pending) begin
                            r_state      <= S_DROP;
                            r_go_pending <= 1'b0;
                        end else begin
                            if (w_tick) begin
                                if (w_deg_try < $signed(10'(DEG_MIN))) begin
                                    r_degree <= 8'(DEG_MIN);
                                    r_dir_up <= 1'b1;
                                end else if (w_deg_try > $signed(10'(DEG_MAX))) begin
                                    r_degree <= 8'(DEG_MAX);
                                    r_dir_up <= 1'b0;
                                end else begin
                                    r_degree <= w_deg_try[7:0];
                                end
                            end
                            if (go)
                                r_go_pending <= 1'b1;
                        end
                    end

                    S_DROP: begin
                        if (w_tick) begin
                            if (hit) begin
                                r_grab_index  <= hit_index;
                                r_grab_weight <= hit_weight;
                                r_grabbed     <= 1'b1;
                                r_state       <= S_RETRACT;
                            end else if (w_len_add[LW:FRAC] >= LEN_MAX_W) begin
                                r_length  <= LEN_HI;
                                r_grabbed <= 1'b0;
                                r_state   <= S_RETRACT;
                            end else begin
                                r_length <= w_len_add[LW-1:0];
                            end
                        end
                    end

                    S_RETRACT: begin
                        if (w_bomb_ok) begin
                            r_grabbed   <= 1'b0;
                            r_bomb_used <= 1'b1;
                        end
                        if (w_tick) begin
                            if (w_len_sub[LW] || (w_len_sub[LW-1:FRAC] <= LEN_MIN_W)) begin
                                r_length <= LEN_LO;
                                if (w_keep) begin
                                    r_state         <= S_COLLECT;
                                    r_collect       <= 1'b1;
                                    r_collect_index <= r_grab_index;
                                end else begin
                                    r_state <= S_SWING;
                                end
                            end else begin
                                r_length <= w_len_sub[LW-1:0];
                            end
                        end
                    end

                    S_COLLECT: begin
                        r_grabbed <= 1'b0;
                        r_state   <= S_SWING;
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_end_x <= 10'(ORIGIN_X);
            r_end_y <= 10'(ORIGIN_Y);
        end else begin
            r_end_x <= cos_neg ? (10'(ORIGIN_X) - w_dx) : (10'(ORIGIN_X) + w_dx);
            r_end_y <= 10'(ORIGIN_Y) + w_dy;
        end
    end

    assign degree        = r_degree;
    assign rope_len      = w_rope_len;
    assign end_x         = r_end_x;
    assign end_y         = r_end_y;
    assign fsm_state     = r_state;
    assign grabbed       = r_grabbed;
    assign grab_index    = r_grab_index;
    assign collect       = r_collect;
    assign collect_index = r_collect_index;
    assign bomb_used     = r_bomb_used;

endmodule

// File: tb/tb_rope_ctrl.sv
// Randomised and directed bench for rope_ctrl, compared cycle by cycle with a
// behavioural model of the rope rules (FRAME_TICKS shortened to 4).
module tb_rope_ctrl;

    localparam int FT        = 4;
    localparam int ORIGIN_X  = 160;
    localparam int ORIGIN_Y  = 45;
    localparam int DEG_MIN   = 15;
    localparam int DEG_MAX   = 165;
    localparam int DEG_START = 90;
    localparam int LEN_MIN   = 10;
    localparam int LEN_MAX   = 200;
    localparam int FRAC      = 8;
    localparam int ROT_STEP  = 1;
    localparam int DOWN_STEP = 768;
    localparam int UP_STEP   = 768;

    localparam int IDLE = 0, SWING = 1, DROP = 2, RETRACT = 3, COLLECT = 4;

    logic       clock = 1'b0;
    logic       resetn;
    logic       enable, hold, go, bomb, hit, cos_neg;
    logic [3:0] hit_index;
    logic [2:0] hit_weight;
    logic [8:0] cos_mag, sin_mag;
    logic [7:0] degree;
    logic [9:0] rope_len, end_x, end_y;
    logic [2:0] fsm_state;
    logic       grabbed, collect, bomb_used;
    logic [3:0] grab_index, collect_index;

    rope_ctrl #(.FRAME_TICKS(FT)) dut (
        .clock(clock), .resetn(resetn), .enable(enable), .hold(hold), .go(go),
        .bomb(bomb), .hit(hit), .hit_index(hit_index), .hit_weight(hit_weight),
        .cos_mag(cos_mag), .cos_neg(cos_neg), .sin_mag(sin_mag),
        .degree(degree), .rope_len(rope_len), .end_x(end_x), .end_y(end_y),
        .fsm_state(fsm_state), .grabbed(grabbed), .grab_index(grab_index),
        .collect(collect), .collect_index(collect_index), .bomb_used(bomb_used)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Trig lookup stand-ins: arbitrary values per degree, driven from the model.
    int cos_tbl[256];
    int sin_tbl[256];
    bit neg_tbl[256];

    int m_state, m_deg, m_dir, m_len, m_cnt, m_gp, m_grab, m_gidx, m_gw;
    int m_col, m_cidx, m_bu, m_ex, m_ey, m_swing_ticks;

    function automatic void m_reset();
        m_state = IDLE; m_deg = DEG_START; m_dir = -1; m_len = LEN_MIN << FRAC;
        m_cnt = 0; m_gp = 0; m_grab = 0; m_gidx = 0; m_gw = 0;
        m_col = 0; m_cidx = 0; m_bu = 0; m_ex = ORIGIN_X; m_ey = ORIGIN_Y;
    endfunction

    task automatic drive_trig();
        cos_mag = 9'(cos_tbl[m_deg]);
        sin_mag = 9'(sin_tbl[m_deg]);
        cos_neg = neg_tbl[m_deg];
    endtask

    task automatic model_step();
        int ln, px, py, nd, dec;
        bit tick, keep;
        if (!resetn) begin
            m_reset();
            return;
        end
        ln   = m_len >> FRAC;
        px   = (ln * int'(cos_mag)) >> 8;
        py   = (ln * int'(sin_mag)) >> 8;
        m_ex = (cos_neg ? ORIGIN_X - px : ORIGIN_X + px) & 1023;
        m_ey = (ORIGIN_Y + py) & 1023;
        tick = (m_cnt == FT - 1) && !hold;
        if (tick) m_cnt = 0;
        else if (m_cnt < FT - 1) m_cnt++;
        m_col = 0;
        m_bu  = 0;
        if (!enable) begin
            m_state = IDLE; m_deg = DEG_START; m_dir = -1; m_len = LEN_MIN << FRAC;
            m_gp = 0; m_grab = 0;
            return;
        end
        case (m_state)
            IDLE: m_state = SWING;
            SWING: begin
                if (tick && m_gp != 0) begin
                    m_state = DROP;
                    m_gp = 0;
                end else begin
                    if (tick) begin
                        m_swing_ticks++;
                        nd = m_deg + m_dir * ROT_STEP;
                        if (nd < DEG_MIN) begin nd = DEG_MIN; m_dir = 1; end
                        else if (nd > DEG_MAX) begin nd = DEG_MAX; m_dir = -1; end
                        m_deg = nd;
                    end
                    if (go) m_gp = 1;
                end
            end
            DROP: if (tick) begin
                if (hit) begin
                    m_gidx = hit_index; m_gw = hit_weight; m_grab = 1; m_state = RETRACT;
                end else begin
                    m_len += DOWN_STEP;
                    if ((m_len >> FRAC) >= LEN_MAX) begin
                        m_len = LEN_MAX << FRAC; m_grab = 0; m_state = RETRACT;
                    end
                end
            end
            RETRACT: begin
                keep = (m_grab != 0) && !bomb;
                if (m_grab != 0 && bomb) begin m_grab = 0; m_bu = 1; end
                if (tick) begin
                    dec = keep ? ((UP_STEP >> m_gw) > 0 ? (UP_STEP >> m_gw) : 1) : UP_STEP;
                    m_len -= dec;
                    if (m_len < ((LEN_MIN + 1) << FRAC)) begin
                        m_len = LEN_MIN << FRAC;
                        if (keep) begin m_state = COLLECT; m_col = 1; m_cidx = m_gidx; end
                        else m_state = SWING;
                    end
                end
            end
            COLLECT: begin
                m_grab = 0;
                m_state = SWING;
            end
            default: m_state = IDLE;
        endcase
    endtask

    task automatic compare_all();
        check("state", fsm_state, m_state);
        check("degree", degree, m_deg);
        check("rope_len", rope_len, m_len >> FRAC);
        check("end_x", end_x, m_ex);
        check("end_y", end_y, m_ey);
        check("grabbed", grabbed, m_grab);
        check("grab_index", grab_index, m_gidx);
        check("collect", collect, m_col);
        check("collect_index", collect_index, m_cidx);
        check("bomb_used", bomb_used, m_bu);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
        drive_trig();
    endtask

    // Waits until just after a swing tick (counter back at zero).
    task automatic wait_swing_tick();
        int k = 0;
        while (!(m_state == SWING && m_cnt == 0) && k < 3000) begin cycle(); k++; end
        check("wait_swing", fsm_state, SWING);
    endtask

    task automatic wait_swing_deg(input int d);
        int k = 0;
        while (!(m_state == SWING && m_deg == d && m_cnt == 0) && k < 3000) begin cycle(); k++; end
        check("wait_deg", degree, d);
    endtask

    task automatic wait_drop_len(input int l);
        int k = 0;
        while (!(m_state == DROP && (m_len >> FRAC) == l && m_cnt == 0) && k < 3000) begin cycle(); k++; end
        check("wait_len", rope_len, l);
    endtask

    task automatic fire();
        wait_swing_tick();
        go = 1'b1;
        cycle();
        go = 1'b0;
    endtask

    task automatic grab_at(input int l, input int idx, input int w);
        fire();
        wait_drop_len(l);
        hit = 1'b1; hit_index = 4'(idx); hit_weight = 3'(w);
        repeat (4) cycle();
        hit = 1'b0;
    endtask

    initial begin
        int k, n_col, col_idx, n_bu, max_len, saved, sdir, exp_deg;
        bit left;
        resetn = 1'b0; enable = 1'b0; hold = 1'b0; go = 1'b0; bomb = 1'b0; hit = 1'b0;
        hit_index = '0; hit_weight = '0;
        for (int i = 0; i < 256; i++) begin
            cos_tbl[i] = $urandom_range(0, 256);
            sin_tbl[i] = $urandom_range(0, 256);
            neg_tbl[i] = 1'($urandom);
        end
        m_reset();
        m_swing_ticks = 0;
        drive_trig();
        #12;
        compare_all();
        resetn = 1'b1;

        // Free swing: 90 down to 15 in 75 ticks, then back and forth in range.
        enable = 1'b1;
        k = 0;
        while (m_swing_ticks < 75 && k < 1000) begin cycle(); k++; end
        check("swing_75", degree, DEG_MIN);
        k = 0;
        while (m_swing_ticks < 330 && k < 2000) begin
            cycle();
            check("deg_range", int'(degree >= DEG_MIN && degree <= DEG_MAX), 1);
            k++;
        end
        check("swing_done", m_swing_ticks, 330);

        // Drop that misses: full extension then retract at angle 60.
        wait_swing_deg(60);
        go = 1'b1; cycle(); go = 1'b0;
        left = 0; max_len = 0;
        for (int i = 0; i < 1500; i++) begin
            cycle();
            check("miss_deg", degree, 60);
            check("miss_collect", collect, 0);
            if (int'(rope_len) > max_len) max_len = rope_len;
            if (m_state != SWING) left = 1;
            else if (left) break;
        end
        check("miss_max", max_len, LEN_MAX);
        check("miss_back", fsm_state, SWING);

        // Grab at length 40, weight 2: retract step 192 and a single collect.
        grab_at(40, 5, 2);
        check("grab_flag", grabbed, 1);
        check("grab_idx", grab_index, 5);
        check("grab_len", rope_len, 40);
        repeat (4) cycle();
        check("grab_step", rope_len, 39);
        n_col = 0; col_idx = 0;
        for (int i = 0; i < 1000 && m_state != SWING; i++) begin
            cycle();
            if (collect) begin n_col++; col_idx = collect_index; end
        end
        check("grab_ncollect", n_col, 1);
        check("grab_cidx", col_idx, 5);
        check("grab_cleared", grabbed, 0);

        // Bomb while retracting a stone; a second bomb is ignored.
        grab_at(100, 9, 3);
        repeat (8) cycle();
        bomb = 1'b1; cycle(); bomb = 1'b0;
        check("bomb_pulse", bomb_used, 1);
        check("bomb_grab", grabbed, 0);
        n_bu = 0; n_col = 0;
        repeat (3) cycle();
        bomb = 1'b1; cycle(); bomb = 1'b0;
        check("bomb_second", bomb_used, 0);
        k = 0;
        while (m_cnt != 0 && k < 8) begin cycle(); k++; end
        saved = m_len;
        repeat (4) cycle();
        check("bomb_step", rope_len, (saved - UP_STEP) >> FRAC);
        for (int i = 0; i < 1000 && m_state != SWING; i++) begin
            cycle();
            if (collect) n_col++;
            if (bomb_used) n_bu++;
        end
        check("bomb_ncollect", n_col, 0);
        check("bomb_nused", n_bu, 0);

        // Stall: hold keeps the counter saturated, tick lands on release.
        wait_swing_tick();
        hold = 1'b1;
        saved = m_deg; sdir = m_dir;
        for (int i = 0; i < 20; i++) begin
            cycle();
            check("stall_deg", degree, saved);
        end
        hold = 1'b0;
        cycle();
        exp_deg = saved + sdir * ROT_STEP;
        if (exp_deg < DEG_MIN) exp_deg = DEG_MIN;
        if (exp_deg > DEG_MAX) exp_deg = DEG_MAX;
        check("stall_release", degree, exp_deg);

        // Randomised traffic.
        for (int i = 0; i < 12000; i++) begin
            enable     = ($urandom_range(0, 599) != 0);
            hold       = ($urandom_range(0, 7) == 0);
            go         = ($urandom_range(0, 39) == 0);
            bomb       = ($urandom_range(0, 29) == 0);
            hit        = ($urandom_range(0, 24) == 0);
            hit_index  = 4'($urandom);
            hit_weight = 3'($urandom);
            cycle();
        end
        enable = 1'b1; hold = 1'b0; go = 1'b0; bomb = 1'b0; hit = 1'b0;

        // Asynchronous reset in the middle of a drop.
        fire();
        wait_drop_len(52);
        repeat (2) cycle();
        #3;
        resetn = 1'b0;
        #1;
        m_reset();
        compare_all();
        drive_trig();
        cycle();
        resetn = 1'b1;
        repeat (12) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
